bmp_pixel_reader: RTL and testbench
===================================

# bmp_pixel_reader

Streaming successor to the team's one-shot BMP loader. It fetches raw interleaved pixel bytes from a byte-wide frame memory and converts BMP bottom-up row order into top-down raster order. Row padding to a 4-byte stride is honoured. Each pixel's bytes are split into separate colour channels and presented as a ready/valid pixel stream with frame and line markers. The block sits between the frame memory and every downstream filter stage.

## Interface
Parameters:
- WIDTH, 4: pixels per row (≥1)
- HEIGHT, 4: rows per frame (≥1)
- DATA_W, 8: bits per channel byte
- CHANNELS, 3: bytes per pixel, 3 (RGB) or 4 (RGBA)
- BGR, 1: 1 = memory byte order is B,G,R[,A]; 0 = R,G,B[,A]
- FLIP, 1: 1 = memory row 0 is the bottom image row; 0 = top row
- PAD4, 1: 1 = row stride is WIDTH*CHANNELS rounded up to a multiple of 4; 0 = no padding
- ADDR_W, 16: memory address width

Ports:
- HCLK  in  1  clock; all logic on the rising edge
- HRESETn  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- mem_rd  out  1  byte read strobe
- mem_addr  out  ADDR_W  byte address
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd
- out_valid  out  1  pixel available
- out_ready  in  1  downstream accepts pixel
- out_pix  out  CHANNELS*DATA_W  R in bits [DATA_W-1:0], then G, B, A
- out_sof  out  1  first pixel of frame (qualified by out_valid)
- out_eol  out  1  last pixel of a row
- out_eof  out  1  last pixel of frame
- busy  out  1  high from start acceptance until frame done
- done  out  1  one-cycle pulse after the final pixel handshake

## Operation
- States:
  - IDLE: start=1 leads to READ, with row=col=k=0 and busy=1.
  - READ: issues CHANNELS consecutive reads (k=0..CHANNELS-1), one per cycle. After the k=CHANNELS-1 read it goes to LAST.
  - LAST: captures the final byte and goes to OUT.
  - OUT: holds out_valid=1 until out_ready=1. On that handshake it advances col (and row at col=WIDTH-1), then goes to READ. If the pixel was the last in the frame, it goes to IDLE instead.
- Address arithmetic:
  - STRIDE = WIDTH*CHANNELS when PAD4=0, otherwise ((WIDTH*CHANNELS+3)/4)*4.
  - srow = HEIGHT-1-row when FLIP=1, otherwise row.
  - mem_addr = srow*STRIDE + col*CHANNELS + k.
  - Computed with ADDR_W-bit unsigned arithmetic. The parameter check requires HEIGHT*STRIDE ≤ 2^ADDR_W.
- Channel mapping:
  - Byte k lands in output channel k when BGR=0.
  - When BGR=1, bytes 0 and 2 swap; byte 3 (A) is always channel 3.
- Flags in OUT:
  - out_sof=1 when row=0 and col=0.
  - out_eol=1 when col=WIDTH-1.
  - out_eof=1 when out_eol=1 and row=HEIGHT-1.
  - All flags are 0 whenever out_valid=0.
- out_pix and the flags stay stable while out_valid=1 and out_ready=0.
- start is ignored while busy=1.
- If start=1 in the same cycle as done=1 (state IDLE), a new frame begins.
- Padding bytes are never read.

## Timing
- Reset (HRESETn=0 at a rising edge) forces state IDLE from the next cycle, with all of the following low/zero: mem_rd, mem_addr, out_valid, out_pix, out_sof, out_eol, out_eof, busy, done.
- Reset mid-frame abandons the frame with no done pulse.
- Cycle t: start is sampled in IDLE.
  - t+1 through t+CHANNELS: mem_rd=1, with k=0..CHANNELS-1.
  - Byte k is registered at the end of cycle t+2+k.
  - out_valid=1 from cycle t+CHANNELS+2.
- First-pixel latency: CHANNELS+2 cycles from start.
- Per-pixel cost with out_ready held high: CHANNELS+2 cycles, so 5 for RGB and 6 for RGBA.
- On a handshake at cycle h:
  - out_valid=0 at h+1.
  - mem_rd=1 at h+1 for the next pixel.
- After the final handshake at cycle h: done=1 and busy=0 at h+1 only.
- mem_rd is 0 in IDLE, LAST and OUT.

## Test plan
- WIDTH=2, HEIGHT=2, CHANNELS=3, BGR=1, FLIP=1, PAD4=1 (STRIDE=8). Memory addr 8..10 = 0x03,0x02,0x01; addr 0..2 = 0x13,0x12,0x11. Expect the first pixel at out_pix=0x030201 (R=0x01) with sof=1, and the third pixel at 0x131211 with eol=0. The address sequence starts 8,9,10,11,12,13,0. Padding addresses 6, 7, 14, 15 are never issued.
- Same parameters with out_ready held high: pixels at cycles t+5, t+10, t+15, t+20; eof on the 4th pixel; done at t+21.
- CHANNELS=4, BGR=0, FLIP=0, PAD4=0, WIDTH=3, HEIGHT=1. Expect addresses 0..11 in order, out_pix[31:24] equal to the byte at addr 3, and eol and eof both set on the 3rd pixel.
- Backpressure: out_ready=0 for 7 cycles on pixel 2. Expect out_pix and flags stable, mem_rd=0 throughout, and the next reads starting the cycle after out_ready rises.
- HRESETn=0 during READ of pixel 3. Next cycle: busy=0, mem_rd=0, out_valid=0, no done pulse. A new start then re-reads from the first-pixel address.
- A start pulse while busy has no effect; start asserted in the done cycle launches a second frame whose first mem_rd follows one cycle later.

Source files
------------

// File: rtl/bmp_pixel_reader_if.sv
// bmp_pixel_reader_if
//   Bundles the two buses of bmp_pixel_reader: the byte-wide frame-memory
//   read port and the outgoing pixel stream.
//
//   Memory port : mem_rd / mem_addr (reader -> memory). mem_rdata
//                 (memory -> reader) is valid exactly one cycle after
//                 mem_rd.
//   Pixel stream: out_valid / out_pix / out_sof / out_eol / out_eof
//                 (reader -> sink). out_ready (sink -> reader).
//
//   Stream handshake: a pixel transfers in any cycle where out_valid and
//   out_ready are both 1 at the rising edge. Once out_valid is raised it
//   stays high, with out_pix and the flags unchanged, until that transfer.
//   out_valid never depends on out_ready.
//
//   master modport: the reader. slave modport: memory plus downstream sink.
interface bmp_pixel_reader_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int ADDR_W   = 16
);
  logic                         mem_rd;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS*DATA_W-1:0]   out_pix;
  logic                         out_sof;
  logic                         out_eol;
  logic                         out_eof;

  modport master (
    output mem_rd, mem_addr, out_valid, out_pix, out_sof, out_eol, out_eof,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_valid, out_pix, out_sof, out_eol, out_eof,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/bmp_pixel_reader.sv
// bmp_pixel_reader
//   Walks a BMP-style frame stored as interleaved bytes in a byte-wide
//   memory and emits it as a top-down raster pixel stream. Rows may be
//   stored bottom-up (FLIP) and padded to a 4-byte stride (PAD4); padding
//   bytes are skipped. Each pixel's bytes are routed into channel slots
//   (R lowest, then G, B, A), swapping R/B when memory order is BGR.
//
// Ports
//   HCLK, HRESETn : clock, synchronous active-low reset
//   start         : begin a frame (only looked at while idle)
//   busy          : frame in progress
//   done          : one-cycle pulse after the last pixel transfer
//   dbg_state     : current FSM state (0 idle, 1 read, 2 last, 3 out)
//   bus           : memory read port + pixel stream (see interface)
module bmp_pixel_reader #(
  parameter int WIDTH    = 4,
  parameter int HEIGHT   = 4,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int BGR      = 1,
  parameter int FLIP     = 1,
  parameter int PAD4     = 1,
  parameter int ADDR_W   = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state,
  bmp_pixel_reader_if.master  bus
);

  localparam int ROW_BYTES = WIDTH * CHANNELS;
  localparam int STRIDE    = (PAD4 != 0) ? ((ROW_BYTES + 3) / 4) * 4 : ROW_BYTES;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (CHANNELS != 3 && CHANNELS != 4) begin : g_bad_channels
    $error("bmp_pixel_reader: CHANNELS must be 3 or 4");
  end
  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_size
    $error("bmp_pixel_reader: WIDTH and HEIGHT must be at least 1");
  end
  if (longint'(HEIGHT) * longint'(STRIDE) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("bmp_pixel_reader: frame does not fit in ADDR_W address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LAST, S_OUT} state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [1:0]       k;

  logic last_col, last_row;
  assign last_col  = (col == COL_W'(WIDTH - 1));
  assign last_row  = (row == ROW_W'(HEIGHT - 1));
  assign dbg_state = state;

  // Address of byte 0 of pixel (r, c). Later bytes are consecutive, so
  // the READ state just increments the registered address.
  function automatic logic [ADDR_W-1:0] pix_base(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    logic [ADDR_W-1:0] srow;
    if (FLIP != 0) srow = ADDR_W'(HEIGHT - 1) - ADDR_W'(r);
    else           srow = ADDR_W'(r);
    return srow * ADDR_W'(STRIDE) + ADDR_W'(c) * ADDR_W'(CHANNELS);
  endfunction

  // Output channel slot for memory byte kk; alpha (byte 3) never moves.
  function automatic int slot(input logic [1:0] kk);
    if (BGR != 0 && kk == 2'd0) return 2;
    if (BGR != 0 && kk == 2'd2) return 0;
    return int'(kk);
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state         <= S_IDLE;
      row           <= '0;
      col           <= '0;
      k             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pix   <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_READ;
            busy         <= 1'b1;
            row          <= '0;
            col          <= '0;
            k            <= '0;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= pix_base('0, '0);
          end
        end
        S_READ: begin
          // Data for the read issued last cycle arrives now.
          if (k != 2'd0)
            bus.out_pix[slot(k - 2'd1)*DATA_W +: DATA_W] <= bus.mem_rdata;
          if (k == 2'(CHANNELS - 1)) begin
            state        <= S_LAST;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
          end else begin
            k            <= k + 2'd1;
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end
        end
        S_LAST: begin
          bus.out_pix[slot(2'(CHANNELS - 1))*DATA_W +: DATA_W] <= bus.mem_rdata;
          state         <= S_OUT;
          bus.out_valid <= 1'b1;
          bus.out_sof   <= (row == '0) && (col == '0);
          bus.out_eol   <= last_col;
          bus.out_eof   <= last_col && last_row;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_eof   <= 1'b0;
            k             <= '0;
            if (last_col && last_row) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= S_READ;
              bus.mem_rd <= 1'b1;
              if (last_col) begin
                row          <= row + 1'b1;
                col          <= '0;
                bus.mem_addr <= pix_base(row + 1'b1, '0);
              end else begin
                col          <= col + 1'b1;
                bus.mem_addr <= pix_base(row, col + 1'b1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_pixel_reader.sv
module tb_bmp_pixel_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b, start_a, start_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [1:0] dbg_a, dbg_b;

  int n_chk = 0;
  int n_err = 0;

  // DUT A: 2x2 RGB, BGR memory order, bottom-up rows, padded stride 8
  bmp_pixel_reader_if #(.DATA_W(8), .CHANNELS(3), .ADDR_W(16)) ifa();
  bmp_pixel_reader #(.WIDTH(2), .HEIGHT(2), .DATA_W(8), .CHANNELS(3), .BGR(1),
                     .FLIP(1), .PAD4(1), .ADDR_W(16)) dut_a (
    .HCLK(clk), .HRESETn(rst_a), .start(start_a), .busy(busy_a),
    .done(done_a), .dbg_state(dbg_a), .bus(ifa));

  // DUT B: 3x1 RGBA, RGB order, top-down rows, no padding
  bmp_pixel_reader_if #(.DATA_W(8), .CHANNELS(4), .ADDR_W(16)) ifb();
  bmp_pixel_reader #(.WIDTH(3), .HEIGHT(1), .DATA_W(8), .CHANNELS(4), .BGR(0),
                     .FLIP(0), .PAD4(0), .ADDR_W(16)) dut_b (
    .HCLK(clk), .HRESETn(rst_b), .start(start_b), .busy(busy_b),
    .done(done_b), .dbg_state(dbg_b), .bus(ifb));

  // ---------------- memory models ----------------
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  always @(posedge clk) if (ifa.mem_rd) ifa.mem_rdata <= mem_a[ifa.mem_addr[3:0]];
  always @(posedge clk) if (ifb.mem_rd) ifb.mem_rdata <= mem_b[ifb.mem_addr[3:0]];

  // ---------------- scoreboard queues ----------------
  logic [26:0] exp_qa[$];   // {sof, eol, eof, pix}
  logic [34:0] exp_qb[$];
  logic [15:0] addr_qa[$];
  logic [15:0] addr_qb[$];
  int          hs_qa[$], hs_qb[$], done_qa[$], done_qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  logic [26:0] held_a;
  logic        held_va = 1'b0;
  logic [34:0] held_b;
  logic        held_vb = 1'b0;

  always @(negedge clk) begin
    logic [26:0] cur;
    if (ifa.mem_rd) begin
      chk("a_addr_expected", 64'(addr_qa.size() != 0), 64'd1);
      if (addr_qa.size() != 0) chk("a_addr", 64'(ifa.mem_addr), 64'(addr_qa.pop_front()));
    end
    if (ifa.out_valid) chk("a_rd_while_valid", 64'(ifa.mem_rd), 64'd0);
    if (!ifa.out_valid)
      chk("a_flags_idle", 64'({ifa.out_sof, ifa.out_eol, ifa.out_eof}), 64'd0);
    if (ifa.out_valid) begin
      cur = {ifa.out_sof, ifa.out_eol, ifa.out_eof, ifa.out_pix};
      if (held_va) chk("a_hold_stable", 64'(cur), 64'(held_a));
      held_a  = cur;
      held_va = !ifa.out_ready;
    end else begin
      held_va = 1'b0;
    end
    if (ifa.out_valid && ifa.out_ready) begin
      chk("a_pix_expected", 64'(exp_qa.size() != 0), 64'd1);
      if (exp_qa.size() != 0)
        chk("a_pix", 64'({ifa.out_sof, ifa.out_eol, ifa.out_eof, ifa.out_pix}),
            64'(exp_qa.pop_front()));
      chk("a_hs_expected", 64'(hs_qa.size() != 0), 64'd1);
      if (hs_qa.size() != 0) chk("a_hs_cycle", 64'(cyc), 64'(hs_qa.pop_front()));
    end
    if (done_a) begin
      chk("a_done_expected", 64'(done_qa.size() != 0), 64'd1);
      if (done_qa.size() != 0) chk("a_done_cycle", 64'(cyc), 64'(done_qa.pop_front()));
      chk("a_busy_at_done", 64'(busy_a), 64'd0);
    end
  end

  always @(negedge clk) begin
    logic [34:0] cur;
    if (ifb.mem_rd) begin
      chk("b_addr_expected", 64'(addr_qb.size() != 0), 64'd1);
      if (addr_qb.size() != 0) chk("b_addr", 64'(ifb.mem_addr), 64'(addr_qb.pop_front()));
    end
    if (!ifb.out_valid)
      chk("b_flags_idle", 64'({ifb.out_sof, ifb.out_eol, ifb.out_eof}), 64'd0);
    if (ifb.out_valid) begin
      cur = {ifb.out_sof, ifb.out_eol, ifb.out_eof, ifb.out_pix};
      if (held_vb) chk("b_hold_stable", 64'(cur), 64'(held_b));
      held_b  = cur;
      held_vb = !ifb.out_ready;
    end else begin
      held_vb = 1'b0;
    end
    if (ifb.out_valid && ifb.out_ready) begin
      chk("b_pix_expected", 64'(exp_qb.size() != 0), 64'd1);
      if (exp_qb.size() != 0)
        chk("b_pix", 64'({ifb.out_sof, ifb.out_eol, ifb.out_eof, ifb.out_pix}),
            64'(exp_qb.pop_front()));
      chk("b_hs_expected", 64'(hs_qb.size() != 0), 64'd1);
      if (hs_qb.size() != 0) chk("b_hs_cycle", 64'(cyc), 64'(hs_qb.pop_front()));
    end
    if (done_b) begin
      chk("b_done_expected", 64'(done_qb.size() != 0), 64'd1);
      if (done_qb.size() != 0) chk("b_done_cycle", 64'(cyc), 64'(done_qb.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Top-down raster of DUT A: image row 0 lives at memory row 1 (addr 8).
  task automatic push_data_a();
    int seq[12] = '{8, 9, 10, 11, 12, 13, 0, 1, 2, 3, 4, 5};
    exp_qa.push_back({1'b1, 1'b0, 1'b0, 24'h030201});
    exp_qa.push_back({1'b0, 1'b1, 1'b0, 24'h060504});
    exp_qa.push_back({1'b0, 1'b0, 1'b0, 24'h131211});
    exp_qa.push_back({1'b0, 1'b1, 1'b1, 24'h161514});
    for (int i = 0; i < 12; i++) addr_qa.push_back(16'(seq[i]));
  endtask

  // Free-running timing: one pixel every 5 cycles, done one cycle later.
  task automatic push_timing_a(input int t);
    for (int i = 1; i <= 4; i++) hs_qa.push_back(t + 5 * i);
    done_qa.push_back(t + 21);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t1, t2, t3, t4, tb;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hEE;
      mem_b[i] = (i < 12) ? 8'(8'h40 + i) : 8'hEE;
    end
    mem_a[8] = 8'h03; mem_a[9]  = 8'h02; mem_a[10] = 8'h01;
    mem_a[11] = 8'h06; mem_a[12] = 8'h05; mem_a[13] = 8'h04;
    mem_a[0] = 8'h13; mem_a[1]  = 8'h12; mem_a[2]  = 8'h11;
    mem_a[3] = 8'h16; mem_a[4]  = 8'h15; mem_a[5]  = 8'h14;

    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_a_rd",    64'(ifa.mem_rd), 64'd0);
    chk("rst_a_addr",  64'(ifa.mem_addr), 64'd0);
    chk("rst_a_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_a_pix",   64'(ifa.out_pix), 64'd0);
    chk("rst_a_flags", 64'({ifa.out_sof, ifa.out_eol, ifa.out_eof}), 64'd0);
    chk("rst_a_busy",  64'(busy_a), 64'd0);
    chk("rst_a_done",  64'(done_a), 64'd0);
    chk("rst_b_rd",    64'(ifb.mem_rd), 64'd0);
    chk("rst_b_pix",   64'(ifb.out_pix), 64'd0);
    chk("rst_b_busy",  64'(busy_b), 64'd0);
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    repeat (2) tick();

    // Frame 1: free-running, with a stray start while busy.
    t1 = cyc;
    push_data_a();
    push_timing_a(t1);
    pulse_start_a();
    wait_until(t1 + 7);
    pulse_start_a();

    // Frame 2: launched in frame 1's done cycle, backpressure on pixel 2.
    t2 = t1 + 21;
    push_data_a();
    hs_qa.push_back(t2 + 5);  hs_qa.push_back(t2 + 17);
    hs_qa.push_back(t2 + 22); hs_qa.push_back(t2 + 27);
    done_qa.push_back(t2 + 28);
    wait_until(t2);
    start_a = 1'b1;
    @(negedge clk);
    chk("done_cycle_done", 64'(done_a), 64'd1);
    chk("done_cycle_busy", 64'(busy_a), 64'd0);
    tick();
    start_a = 1'b0;
    @(negedge clk);
    chk("restart_rd", 64'(ifa.mem_rd), 64'd1);
    chk("restart_busy", 64'(busy_a), 64'd1);
    wait_until(t2 + 6);
    ifa.out_ready = 1'b0;
    wait_until(t2 + 16);
    @(negedge clk);
    chk("bp_valid", 64'(ifa.out_valid), 64'd1);
    chk("bp_rd", 64'(ifa.mem_rd), 64'd0);
    tick();
    ifa.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rd_low", 64'(ifa.mem_rd), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_release_rd_high", 64'(ifa.mem_rd), 64'd1);
    wait_until(t2 + 30);

    // Frame 3: reset during the reads of pixel 3.
    t3 = cyc;
    push_data_a();
    hs_qa.push_back(t3 + 5); hs_qa.push_back(t3 + 10);
    pulse_start_a();
    wait_until(t3 + 12);
    rst_a = 1'b0;
    tick();
    addr_qa.delete();
    exp_qa.delete();
    @(negedge clk);
    chk("midrst_busy",  64'(busy_a), 64'd0);
    chk("midrst_rd",    64'(ifa.mem_rd), 64'd0);
    chk("midrst_valid", 64'(ifa.out_valid), 64'd0);
    chk("midrst_done",  64'(done_a), 64'd0);
    repeat (2) tick();
    rst_a = 1'b1;

    // Frame 4: fresh frame after the abandoned one.
    t4 = t3 + 20;
    wait_until(t4);
    push_data_a();
    push_timing_a(t4);
    pulse_start_a();
    wait_until(t4 + 25);

    // DUT B: RGBA, no flip, no padding.
    tb = cyc;
    exp_qb.push_back({1'b1, 1'b0, 1'b0, 32'h43424140});
    exp_qb.push_back({1'b0, 1'b0, 1'b0, 32'h47464544});
    exp_qb.push_back({1'b0, 1'b1, 1'b1, 32'h4B4A4948});
    for (int i = 0; i < 12; i++) addr_qb.push_back(16'(i));
    for (int i = 1; i <= 3; i++) hs_qb.push_back(tb + 6 * i);
    done_qb.push_back(tb + 19);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_until(tb + 25);

    chk("end_a_pix_q",  64'(exp_qa.size()), 64'd0);
    chk("end_a_addr_q", 64'(addr_qa.size()), 64'd0);
    chk("end_a_hs_q",   64'(hs_qa.size()), 64'd0);
    chk("end_a_done_q", 64'(done_qa.size()), 64'd0);
    chk("end_b_pix_q",  64'(exp_qb.size()), 64'd0);
    chk("end_b_addr_q", 64'(addr_qb.size()), 64'd0);
    chk("end_b_hs_q",   64'(hs_qb.size()), 64'd0);
    chk("end_b_done_q", 64'(done_qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
